// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, programmable-polarity syncs,
// active-video flag and line/frame/vblank strobes, paced by an internal pixel-tick divider.
module vga_timing_gen #(
  parameter int CNT_W    = 10,
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ROLL = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON    = (HS_POL != 0);
  localparam logic             VS_ON    = (VS_POL != 0);

  logic [DIV_W-1:0] r_div;
  logic             r_pixTick;
  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_active;
  logic             r_lineStart;
  logic             r_frameStart;
  logic             r_vblankStart;

  logic [DIV_W-1:0] w_divNext;
  logic             w_hWrap;
  logic [CNT_W-1:0] w_hNext;
  logic [CNT_W-1:0] w_vNext;
  logic             w_hsyncNext;
  logic             w_vsyncNext;
  logic             w_activeNext;

  // Decode from the next counter values so every registered output matches the count shown with it.
  always_comb begin
    w_divNext    = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    w_hWrap      = (r_hcount == H_LAST);
    w_hNext      = w_hWrap ? '0 : r_hcount + CNT_W'(1);
    w_vNext      = r_vcount;
    if (w_hWrap) begin
      w_vNext = (r_vcount == V_LAST) ? '0 : r_vcount + CNT_W'(1);
    end
    w_hsyncNext  = (w_hNext >= HS_BEG && w_hNext < HS_END) ? HS_ON : ~HS_ON;
    w_vsyncNext  = (w_vNext >= VS_BEG && w_vNext < VS_END) ? VS_ON : ~VS_ON;
    w_activeNext = (w_hNext < H_VIS) && (w_vNext < V_VIS);
  end

  // A tick cancelled by en=0 rolls the divider back one step so it is re-issued on resume.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div         <= '0;
      r_pixTick     <= 1'b0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~HS_ON;
      r_vsync       <= ~VS_ON;
      r_active      <= 1'b1;
      r_lineStart   <= 1'b0;
      r_frameStart  <= 1'b0;
      r_vblankStart <= 1'b0;
    end else if (!en) begin
      r_pixTick     <= 1'b0;
      r_lineStart   <= 1'b0;
      r_frameStart  <= 1'b0;
      r_vblankStart <= 1'b0;
      if (r_pixTick) begin
        r_div <= DIV_ROLL;
      end
    end else begin
      r_div         <= w_divNext;
      r_pixTick     <= (w_divNext == DIV_LAST);
      r_lineStart   <= 1'b0;
      r_frameStart  <= 1'b0;
      r_vblankStart <= 1'b0;
      if (r_pixTick) begin
        r_hcount      <= w_hNext;
        r_vcount      <= w_vNext;
        r_hsync       <= w_hsyncNext;
        r_vsync       <= w_vsyncNext;
        r_active      <= w_activeNext;
        r_lineStart   <= (w_hNext == '0);
        r_frameStart  <= (w_hNext == '0) && (w_vNext == '0);
        r_vblankStart <= (w_hNext == '0) && (w_vNext == V_VIS);
      end
    end
  end

  assign pix_tick     = r_pixTick;
  assign hcount       = r_hcount;
  assign vcount       = r_vcount;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign active       = r_active;
  assign line_start   = r_lineStart;
  assign frame_start  = r_frameStart;
  assign vblank_start = r_vblankStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default VGA, CLK_DIV=1 wide-line high-polarity,
// tiny CLK_DIV=3 raster) scored every clock against a closed-form tick-count model.
module tb_vga_timing_gen;

  typedef struct packed {
    longint d, ha, hf, hs, hb, va, vf, vs, vb;
    bit     hp, vp;
  } cfg_t;

  typedef struct packed {
    logic        tick;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, act, ls, fs, vb;
  } obs_t;

  localparam cfg_t CFG_A = '{d:4, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0};
  localparam cfg_t CFG_B = '{d:1, ha:800, hf:40, hs:128, hb:88, va:4, vf:1, vs:2, vb:2, hp:1'b1, vp:1'b1};
  localparam cfg_t CFG_C = '{d:3, ha:8, hf:2, hs:3, hb:3, va:4, vf:1, vs:2, vb:2, hp:1'b0, vp:1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, enA, rstB, enB, rstC, enC;
  logic        pixTickA, hsA, vsA, actA, lsA, fsA, vbA;
  logic [9:0]  hA, vA;
  logic        pixTickB, hsB, vsB, actB, lsB, fsB, vbB;
  logic [10:0] hB, vB;
  logic        pixTickC, hsC, vsC, actC, lsC, fsC, vbC;
  logic [4:0]  hC, vC;

  vga_timing_gen dutA (
    .clk(clk), .reset(rstA), .en(enA), .pix_tick(pixTickA), .hcount(hA), .vcount(vA),
    .hsync(hsA), .vsync(vsA), .active(actA), .line_start(lsA), .frame_start(fsA),
    .vblank_start(vbA)
  );

  vga_timing_gen #(
    .CNT_W(11), .CLK_DIV(1), .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1), .VS_POL(1)
  ) dutB (
    .clk(clk), .reset(rstB), .en(enB), .pix_tick(pixTickB), .hcount(hB), .vcount(vB),
    .hsync(hsB), .vsync(vsB), .active(actB), .line_start(lsB), .frame_start(fsB),
    .vblank_start(vbB)
  );

  vga_timing_gen #(
    .CNT_W(5), .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(0), .VS_POL(0)
  ) dutC (
    .clk(clk), .reset(rstC), .en(enC), .pix_tick(pixTickC), .hcount(hC), .vcount(vC),
    .hsync(hsC), .vsync(vsC), .active(actC), .line_start(lsC), .frame_start(fsC),
    .vblank_start(vbC)
  );

  int     numTests = 0;
  int     numFail  = 0;
  int     n;
  longint kA = 0, kB = 0, kC = 0;
  obs_t   qA[$], qB[$], qC[$];

  bit winB = 1'b0, winC = 1'b0;
  int cntClkB, cntHsB, cntVsB, cntActB, cntLsB, cntVbB;
  int cntClkC, cntTickC, cntActC, cntLsC, cntFsC, cntVbC;

  // k = enabled edges since reset; a tick is shown after edges k = D-1 (mod D), and each shown
  // tick advances the pixel position on the following edge.
  function automatic obs_t modelOut(cfg_t c, longint k, bit lastEn);
    obs_t   o;
    longint ht, vt, jmin, p, h, v;
    bit     adv;
    ht   = c.ha + c.hf + c.hs + c.hb;
    vt   = c.va + c.vf + c.vs + c.vb;
    jmin = (c.d == 1) ? 1 : c.d - 1;
    p    = (k - 1 >= jmin) ? ((k - 1 - jmin) / c.d + 1) : 0;
    h    = p % ht;
    v    = (p / ht) % vt;
    adv  = lastEn && (k - 1 >= 1) && ((k - 1) % c.d == c.d - 1);
    o.tick = lastEn && (k >= 1) && (k % c.d == c.d - 1);
    o.h    = 11'(h);
    o.v    = 11'(v);
    o.hs   = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
    o.vs   = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
    o.act  = (h < c.ha) && (v < c.va);
    o.ls   = adv && (h == 0);
    o.fs   = adv && (h == 0) && (v == 0);
    o.vb   = adv && (h == 0) && (v == c.va);
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numTests++;
    assert (observed === expected)
    else begin
      numFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic ae, input logic br, input logic be,
                               input logic cr, input logic ce);
    rstA = ar; enA = ae;
    rstB = br; enB = be;
    rstC = cr; enC = ce;
  endtask

  // One clock: predictions pushed at the active edge, popped and compared at the falling edge.
  task automatic stepClk();
    @(posedge clk);
    if (rstA) kA = 0; else if (enA) kA++;
    if (rstB) kB = 0; else if (enB) kB++;
    if (rstC) kC = 0; else if (enC) kC++;
    qA.push_back(modelOut(CFG_A, kA, !rstA && enA));
    qB.push_back(modelOut(CFG_B, kB, !rstB && enB));
    qC.push_back(modelOut(CFG_C, kC, !rstC && enC));
    @(negedge clk);
    checkOutput("sbA", 32'({pixTickA, 11'(hA), 11'(vA), hsA, vsA, actA, lsA, fsA, vbA}), 32'(qA.pop_front()));
    checkOutput("sbB", 32'({pixTickB, hB, vB, hsB, vsB, actB, lsB, fsB, vbB}), 32'(qB.pop_front()));
    checkOutput("sbC", 32'({pixTickC, 11'(hC), 11'(vC), hsC, vsC, actC, lsC, fsC, vbC}), 32'(qC.pop_front()));
    if (winB) begin
      cntClkB++;
      if (hsB) cntHsB++;
      if (vsB) cntVsB++;
      if (pixTickB && actB) cntActB++;
      if (lsB) cntLsB++;
      if (vbB) cntVbB++;
    end
    if (winC) begin
      cntClkC++;
      if (pixTickC) cntTickC++;
      if (pixTickC && actC) cntActC++;
      if (lsC) cntLsC++;
      if (fsC) cntFsC++;
      if (vbC) cntVbC++;
    end
  endtask

  initial begin
    applyStimulus(1, 1, 1, 1, 1, 1);
    repeat (3) stepClk();
    applyStimulus(0, 1, 0, 1, 0, 1);
    checkOutput("A_release_tick", 32'(pixTickA), 32'(0));
    checkOutput("A_release_fs", 32'(fsA), 32'(0));

    n = 1;
    while (!pixTickA && n < 20) begin stepClk(); n++; end
    checkOutput("A_first_tick_clk", 32'(n), 32'(4));
    n = 0;
    do begin stepClk(); n++; end while (!pixTickA && n < 20);
    checkOutput("A_tick_period", 32'(n), 32'(4));

    n = 0;
    while (hA != 799 && n < 4000) begin stepClk(); n++; end
    checkOutput("A_reach_799", 32'(hA), 32'(799));
    checkOutput("A_799_line", 32'(vA), 32'(0));
    n = 0;
    while (hA == 799 && n < 8) begin stepClk(); n++; end
    checkOutput("A_wrap_h", 32'(hA), 32'(0));
    checkOutput("A_wrap_v", 32'(vA), 32'(1));
    checkOutput("A_wrap_ls", 32'(lsA), 32'(1));
    stepClk();
    checkOutput("A_ls_one_clk", 32'(lsA), 32'(0));

    n = 0;
    while (hA != 655 && n < 4000) begin stepClk(); n++; end
    checkOutput("A_reach_655", 32'(hA), 32'(655));
    applyStimulus(0, 0, 0, 1, 0, 1);
    repeat (37) stepClk();
    checkOutput("A_frozen_h", 32'(hA), 32'(655));
    checkOutput("A_frozen_hs", 32'(hsA), 32'(1));
    checkOutput("A_frozen_tick", 32'(pixTickA), 32'(0));
    applyStimulus(0, 1, 0, 1, 0, 1);
    n = 0;
    while (hA == 655 && n < 10) begin stepClk(); n++; end
    checkOutput("A_resume_clks", 32'(n), 32'(4));
    checkOutput("A_resume_h", 32'(hA), 32'(656));
    checkOutput("A_resume_hs", 32'(hsA), 32'(0));

    n = 0;
    while (!fsC && n < 1000) begin stepClk(); n++; end
    checkOutput("C_fs_seen", 32'(fsC), 32'(1));
    {cntClkC, cntTickC, cntActC, cntLsC, cntFsC, cntVbC} = '0;
    winC = 1'b1;
    n = 0;
    do begin stepClk(); n++; end while (!fsC && n < 1000);
    winC = 1'b0;
    checkOutput("C_frame_clks", 32'(cntClkC), 32'(432));
    checkOutput("C_frame_ticks", 32'(cntTickC), 32'(144));
    checkOutput("C_active_ticks", 32'(cntActC), 32'(32));
    checkOutput("C_line_starts", 32'(cntLsC), 32'(9));
    checkOutput("C_frame_starts", 32'(cntFsC), 32'(1));
    checkOutput("C_vblank_starts", 32'(cntVbC), 32'(1));

    n = 0;
    while (!fsB && n < 12000) begin stepClk(); n++; end
    checkOutput("B_fs_seen", 32'(fsB), 32'(1));
    {cntClkB, cntHsB, cntVsB, cntActB, cntLsB, cntVbB} = '0;
    winB = 1'b1;
    n = 0;
    do begin stepClk(); n++; end while (!fsB && n < 12000);
    winB = 1'b0;
    checkOutput("B_frame_clks", 32'(cntClkB), 32'(9504));
    checkOutput("B_hsync_hi_clks", 32'(cntHsB), 32'(1152));
    checkOutput("B_vsync_hi_clks", 32'(cntVsB), 32'(2112));
    checkOutput("B_active_ticks", 32'(cntActB), 32'(3200));
    checkOutput("B_line_starts", 32'(cntLsB), 32'(9));
    checkOutput("B_vblank_starts", 32'(cntVbB), 32'(1));

    n = 0;
    while ((hB != 700 || vB != 3) && n < 12000) begin stepClk(); n++; end
    checkOutput("B_reach_h", 32'(hB), 32'(700));
    checkOutput("B_reach_v", 32'(vB), 32'(3));
    applyStimulus(0, 1, 1, 1, 0, 1);
    stepClk();
    checkOutput("B_rst_h", 32'(hB), 32'(0));
    checkOutput("B_rst_v", 32'(vB), 32'(0));
    checkOutput("B_rst_hs", 32'(hsB), 32'(0));
    checkOutput("B_rst_vs", 32'(vsB), 32'(0));
    checkOutput("B_rst_act", 32'(actB), 32'(1));
    checkOutput("B_rst_strobes", 32'({pixTickB, lsB, fsB, vbB}), 32'(0));
    applyStimulus(0, 1, 0, 1, 0, 1);
    repeat (6) stepClk();
    checkOutput("B_after_rst_h", 32'(hB), 32'(5));

    $display("[TB] %0d tests run, %0d failed", numTests, numFail);
    $finish;
  end

endmodule
